// File: rtl/vsdma_port_arbiter.sv
// vsdma_port_arbiter: shares one vsdma write port and one vsdma read port between
//   NUM_CH channel controllers, round-robin, one burst transaction per grant.
// Latency: m_*areq rises one ui_clk after a request is sampled in IDLE; consecutive
//   grants on a path are separated by at least one IDLE cycle.
// Backpressure: a path keeps its grant until the downstream m_*busy has risen and
//   fallen again; requesters hold ch_*areq until their own ch_*busy bit rises.
//
// Ports (write group shown; the read group mirrors it):
//   ui_clk, ui_rst       single clock, synchronous active-high reset
//   ch_waddr/ch_wsize    packed per-channel command, channel i at [i*W +: W]
//   ch_wareq             per-channel request, one bit per channel
//   ch_wbusy             one-hot: granted channel, REQ entry to last BUSY cycle
//   ch_wdata / m_wdata   per-channel write data, muxed onto the port by grant
//   ch_wvalid            m_wvalid routed to the granted channel
//   m_waddr/m_wsize      command frozen for the whole transaction
//   m_wareq / m_wbusy    downstream request / busy handshake
//   ch_rdata / m_rdata   read data, broadcast to every channel
//   ch_rvalid / m_rvalid read beat strobe routed to the read-granted channel
module vsdma_port_arbiter #(
   parameter int NUM_CH = 3,
   parameter int ADDR_W = 28,
   parameter int SIZE_W = 16,
   parameter int DATA_W = 256
) (
   input  logic                     ui_clk,
   input  logic                     ui_rst,
   // channel side, write
   input  logic [NUM_CH*ADDR_W-1:0] ch_waddr,
   input  logic [NUM_CH-1:0]        ch_wareq,
   input  logic [NUM_CH*SIZE_W-1:0] ch_wsize,
   output logic [NUM_CH-1:0]        ch_wbusy,
   input  logic [NUM_CH*DATA_W-1:0] ch_wdata,
   output logic [NUM_CH-1:0]        ch_wvalid,
   // channel side, read
   input  logic [NUM_CH*ADDR_W-1:0] ch_raddr,
   input  logic [NUM_CH-1:0]        ch_rareq,
   input  logic [NUM_CH*SIZE_W-1:0] ch_rsize,
   output logic [NUM_CH-1:0]        ch_rbusy,
   output logic [DATA_W-1:0]        ch_rdata,
   output logic [NUM_CH-1:0]        ch_rvalid,
   // bridge side, write
   output logic [ADDR_W-1:0]        m_waddr,
   output logic [SIZE_W-1:0]        m_wsize,
   output logic                     m_wareq,
   input  logic                     m_wbusy,
   output logic [DATA_W-1:0]        m_wdata,
   input  logic                     m_wvalid,
   // bridge side, read
   output logic [ADDR_W-1:0]        m_raddr,
   output logic [SIZE_W-1:0]        m_rsize,
   output logic                     m_rareq,
   input  logic                     m_rbusy,
   input  logic [DATA_W-1:0]        m_rdata,
   input  logic                     m_rvalid
);

   localparam int CH_W = $clog2(NUM_CH);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_BUSY = 2'd2
   } arb_state_t;

   // Round-robin pick: first requester after 'last', wrapping modulo NUM_CH.
   // Returns {found, index}. The sum is one bit wider than an index so the
   // wrap can be done by a single conditional subtract.
   function automatic logic [CH_W:0] rr_pick(input logic [NUM_CH-1:0] req,
                                             input logic [CH_W-1:0]   last);
      logic [CH_W:0]   idx;
      logic            found;
      logic [CH_W-1:0] pick;
      found = 1'b0;
      pick  = '0;
      for (int i = 1; i <= NUM_CH; i++) begin
         idx = {1'b0, last} + (CH_W+1)'(i);
         if (idx >= (CH_W+1)'(NUM_CH))
            idx = idx - (CH_W+1)'(NUM_CH);
         if (!found && req[idx[CH_W-1:0]]) begin
            found = 1'b1;
            pick  = idx[CH_W-1:0];
         end
      end
      return {found, pick};
   endfunction

   // Path 0 is the write arbiter, path 1 the read arbiter. Both run the same
   // IDLE -> REQ -> BUSY sequence and never interact, so the same channel may
   // hold a write grant and a read grant at once.
   for (genvar p = 0; p < 2; p++) begin : g_path
      logic [NUM_CH-1:0]        req;
      logic [NUM_CH*ADDR_W-1:0] addr_bus;
      logic [NUM_CH*SIZE_W-1:0] size_bus;
      logic                     m_busy;
      logic                     beat;

      if (p == 0) begin : g_wr_in
         assign req      = ch_wareq;
         assign addr_bus = ch_waddr;
         assign size_bus = ch_wsize;
         assign m_busy   = m_wbusy;
         assign beat     = m_wvalid;
      end else begin : g_rd_in
         assign req      = ch_rareq;
         assign addr_bus = ch_raddr;
         assign size_bus = ch_rsize;
         assign m_busy   = m_rbusy;
         assign beat     = m_rvalid;
      end

      arb_state_t        state;
      logic [CH_W-1:0]   grant;
      logic [CH_W-1:0]   last;
      logic [ADDR_W-1:0] m_addr;
      logic [SIZE_W-1:0] m_size;
      logic              m_areq;
      logic [NUM_CH-1:0] ch_busy;
      logic [CH_W:0]     pick;
      logic              active;
      logic [NUM_CH-1:0] beat_route;

      assign pick   = rr_pick(req, last);
      assign active = (state != ST_IDLE);

      // Beats only reach a channel while a transaction is open; anything the
      // bridge strobes in IDLE is dropped.
      assign beat_route = active ? ({{(NUM_CH-1){1'b0}}, beat} << grant) : '0;

      always_ff @(posedge ui_clk) begin
         if (ui_rst) begin
            state   <= ST_IDLE;
            grant   <= '0;
            last    <= CH_W'(NUM_CH-1);
            m_addr  <= '0;
            m_size  <= '0;
            m_areq  <= 1'b0;
            ch_busy <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  // A busy still high from an earlier burst blocks new grants:
                  // the REQ state would otherwise take it as an acknowledge.
                  if (pick[CH_W] && !m_busy) begin
                     grant   <= pick[CH_W-1:0];
                     m_addr  <= addr_bus[pick[CH_W-1:0]*ADDR_W +: ADDR_W];
                     m_size  <= size_bus[pick[CH_W-1:0]*SIZE_W +: SIZE_W];
                     m_areq  <= 1'b1;
                     ch_busy <= {{(NUM_CH-1){1'b0}}, 1'b1} << pick[CH_W-1:0];
                     state   <= ST_REQ;
                  end
               end
               ST_REQ: begin
                  if (m_busy) begin
                     m_areq <= 1'b0;
                     state  <= ST_BUSY;
                  end
               end
               ST_BUSY: begin
                  // Round-robin pointer only advances once the burst is done,
                  // so a transaction killed by reset does not count as served.
                  if (!m_busy) begin
                     last    <= grant;
                     ch_busy <= '0;
                     state   <= ST_IDLE;
                  end
               end
               default: begin
                  m_areq  <= 1'b0;
                  ch_busy <= '0;
                  state   <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Write path outputs. Data is gated to zero outside a transaction so the
   // port is quiet while idle and during reset.
   assign m_waddr   = g_path[0].m_addr;
   assign m_wsize   = g_path[0].m_size;
   assign m_wareq   = g_path[0].m_areq;
   assign ch_wbusy  = g_path[0].ch_busy;
   assign ch_wvalid = g_path[0].beat_route;
   assign m_wdata   = g_path[0].active ?
                      ch_wdata[g_path[0].grant*DATA_W +: DATA_W] : '0;

   // Read path outputs. Read data is a plain broadcast; only the strobe
   // tells a channel the beat is its own.
   assign m_raddr   = g_path[1].m_addr;
   assign m_rsize   = g_path[1].m_size;
   assign m_rareq   = g_path[1].m_areq;
   assign ch_rbusy  = g_path[1].ch_busy;
   assign ch_rvalid = g_path[1].beat_route;
   assign ch_rdata  = m_rdata;

endmodule
